// File: rtl/load_store_sequencer.sv
// Multicycle load/store sequencer between the control unit and a 64-bit data memory.
// Optional build macro LSS_MISALIGN_TRAP_EN: trap misaligned requests instead of forcing natural alignment.
module load_store_sequencer #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [1:0]  ext_type,
    output logic [63:0] load_data,
    output logic        reg_wr
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_MERGE, S_WRITE, S_LDWB, S_FIN, S_ERR
    } state_t;

    state_t      state, state_d;
    logic [63:0] addr_q;
    logic [63:0] store_data_q;
    logic [63:0] data_buf;
    logic [1:0]  size_q;
    logic        is_store_q;
    logic [7:0]  wait_cnt;
    logic [2:0]  off;
    logic        timeout;

    // Low address bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'b111;
            2'b01:   return 3'b011;
            2'b10:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [63:0] merge_lanes(input logic [63:0] dw, input logic [63:0] sd,
                                                input logic [2:0] lane_off, input logic [1:0] sz);
        logic [63:0] r;
        int o;
        int nb;
        r  = dw;
        o  = int'(lane_off);
        nb = 8 >> sz;
        for (int i = 0; i < 8; i++) begin
            if (i >= o && i < o + nb)
                r[8*i +: 8] = sd[8*(i-o) +: 8];
        end
        return r;
    endfunction

`ifdef LSS_MISALIGN_TRAP_EN
    logic misalign;
    assign off      = addr_q[2:0];
    assign misalign = |(addr[2:0] & lane_mask(size));
`else
    assign off = addr_q[2:0] & ~lane_mask(size_q);
`endif

    assign timeout   = (wait_cnt == 8'(MAX_WAIT)) && !mem_ack;
    assign mem_addr  = {addr_q[63:3], 3'b000};
    assign mem_wdata = data_buf;
    assign load_data = data_buf >> {off, 3'b000};
    assign ext_type  = size_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        busy    = (state != S_IDLE);
        done    = 1'b0;
        err     = 1'b0;
        reg_wr  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef LSS_MISALIGN_TRAP_EN
                    if (misalign) state_d = S_ERR;
                    else
`endif
                    if (is_store && size == 2'b00) state_d = S_WRITE;
                    else                           state_d = S_READ;
                end
            end
            S_READ: begin
                mem_rd = !timeout;
                if (mem_ack) begin
                    state_d = is_store_q ? S_MERGE : S_LDWB;
                end else if (timeout) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_MERGE: state_d = S_WRITE;
            S_WRITE: begin
                mem_wr = !timeout;
                if (mem_ack) begin
                    state_d = S_FIN;
                end else if (timeout) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_LDWB: begin
                reg_wr  = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q       <= '0;
            store_data_q <= '0;
            size_q       <= '0;
            is_store_q   <= 1'b0;
            data_buf     <= '0;
            wait_cnt     <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                addr_q       <= addr;
                store_data_q <= store_data;
                size_q       <= size;
                is_store_q   <= is_store;
            end
            // Full-doubleword stores skip the read and write the request data directly.
            if (state == S_IDLE && state_d == S_WRITE)
                data_buf <= store_data;
            else if (state == S_READ && mem_ack)
                data_buf <= mem_rdata;
            else if (state == S_MERGE)
                data_buf <= merge_lanes(data_buf, store_data_q, off, size_q);
            if (state == S_READ || state == S_WRITE) begin
                if (!mem_ack) wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed testbench for load_store_sequencer with hand-computed expected values.
module tb_load_store_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [1:0]  ext_type;
    logic [63:0] load_data;
    logic        reg_wr;

    int n_vec  = 0;
    int n_miss = 0;

    load_store_sequencer #(.MAX_WAIT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_store   (is_store),
        .size       (size),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ext_type   (ext_type),
        .load_data  (load_data),
        .reg_wr     (reg_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Sub-doubleword store: READ (ack at once), MERGE, WRITE (ack at once), FIN.
    task automatic rmw(input string tag, input logic [63:0] a, input logic [1:0] sz,
                       input logic [63:0] sd, input logic [63:0] rd, input logic [63:0] exp);
        cyc(); start = 1'b1; is_store = 1'b1; size = sz; addr = a; store_data = sd;
        smp();
        cyc(); start = 1'b0; mem_ack = 1'b1; mem_rdata = rd;
        smp(); check({tag, "_rd"}, 64'(mem_rd), 64'd1);
               check({tag, "_addr"}, mem_addr, {a[63:3], 3'b000});
        cyc(); mem_ack = 1'b0;
        smp(); check({tag, "_merge_idle_bus"}, 64'({mem_rd, mem_wr, done}), 64'd0);
        cyc(); mem_ack = 1'b1;
        smp(); check({tag, "_wr"}, 64'(mem_wr), 64'd1);
               check({tag, "_wdata"}, mem_wdata, exp);
        cyc(); mem_ack = 1'b0;
        smp(); check({tag, "_done"}, 64'({done, reg_wr, err}), 64'b100);
        cyc();
        smp(); check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_store = 1'b0; size = 2'b00;
        addr = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        smp();
        check("rst_ctl", 64'({busy, done, err, mem_rd, mem_wr, reg_wr}), 64'd0);
        check("rst_addr", mem_addr, 64'd0);
        check("rst_wdata", mem_wdata, 64'd0);
        check("rst_ldata", load_data, 64'd0);
        check("rst_ext", 64'(ext_type), 64'd0);
        cyc(); reset = 1'b0;

        // lw addr=0x1004
        cyc(); start = 1'b1; is_store = 1'b0; size = 2'b01; addr = 64'h1004;
        smp(); check("lw_c0_busy", 64'(busy), 64'd0);
        cyc(); start = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h8000_0001_0000_0000;
        smp(); check("lw_rd", 64'(mem_rd), 64'd1);
               check("lw_addr", mem_addr, 64'h1000);
               check("lw_c1_done", 64'(done), 64'd0);
        cyc(); mem_ack = 1'b0;
        smp(); check("lw_wb", 64'({reg_wr, done, err, mem_rd}), 64'b1100);
               check("lw_ldata", load_data, 64'h0000_0000_8000_0001);
               check("lw_ext", 64'(ext_type), 64'd1);
        cyc();
        smp(); check("lw_after", 64'({busy, done, reg_wr}), 64'd0);
        cyc();
        smp(); check("lw_hold_ldata", load_data, 64'h0000_0000_8000_0001);
               check("lw_hold_ext", 64'(ext_type), 64'd1);

        // Sub-doubleword stores over a doubleword of 0x11 bytes
        rmw("sb", 64'h2003, 2'b11, 64'h0000_0000_0000_00AB, 64'h1111_1111_1111_1111, 64'h1111_1111_AB11_1111);
        rmw("sh", 64'h200A, 2'b10, 64'hFFFF_FFFF_FFFF_1234, 64'h1111_1111_1111_1111, 64'h1111_1111_1234_1111);
        rmw("sw", 64'h2004, 2'b01, 64'h0000_0000_89AB_CDEF, 64'h1111_1111_1111_1111, 64'h89AB_CDEF_1111_1111);

        // sd addr=0x3000: straight to WRITE
        cyc(); start = 1'b1; is_store = 1'b1; size = 2'b00; addr = 64'h3000;
               store_data = 64'hDEAD_BEEF_0123_4567;
        smp();
        cyc(); start = 1'b0; mem_ack = 1'b1;
        smp(); check("sd_bus", 64'({mem_rd, mem_wr}), 64'b01);
               check("sd_wdata", mem_wdata, 64'hDEAD_BEEF_0123_4567);
               check("sd_addr", mem_addr, 64'h3000);
        cyc(); mem_ack = 1'b0;
        smp(); check("sd_done", 64'({done, reg_wr}), 64'b10);

        // ld with no ack: timeout after 15 cycles in READ
        cyc(); start = 1'b1; is_store = 1'b0; size = 2'b00; addr = 64'h8000;
        smp();
        cyc(); start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            smp(); check($sformatf("to_wait%0d", k), 64'({err, mem_rd}), 64'b01);
            cyc();
        end
        smp(); check("to_err", 64'({err, mem_rd, reg_wr, done, busy}), 64'b10001);
        cyc();
        smp(); check("to_idle", 64'({busy, err}), 64'd0);
               check("to_buf_kept", load_data, 64'hDEAD_BEEF_0123_4567);

        // ld where the ack lands on the limit cycle: ack wins
        cyc(); start = 1'b1; is_store = 1'b0; size = 2'b00; addr = 64'h9000;
        smp();
        cyc(); start = 1'b0;
        for (int k = 1; k < 15; k++) begin
            cyc();
        end
        cyc(); mem_ack = 1'b1; mem_rdata = 64'h0000_0000_0000_55AA;
        smp(); check("lim_ack_noerr", 64'({err, mem_rd}), 64'b01);
        cyc(); mem_ack = 1'b0;
        smp(); check("lim_ack_done", 64'({done, reg_wr, err}), 64'b110);
               check("lim_ack_ldata", load_data, 64'h55AA);

        // lh addr=0x0001
        cyc(); start = 1'b1; is_store = 1'b0; size = 2'b10; addr = 64'h0001;
        smp();
`ifdef LSS_MISALIGN_TRAP_EN
        cyc(); start = 1'b0;
        smp(); check("mis_err", 64'({err, mem_rd, mem_wr, reg_wr, done}), 64'b10000);
        cyc();
        smp(); check("mis_idle", 64'({busy, err}), 64'd0);
`else
        cyc(); start = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        smp(); check("mis_addr", mem_addr, 64'h0000);
               check("mis_rd", 64'({mem_rd, err}), 64'b10);
        cyc(); mem_ack = 1'b0;
        smp(); check("mis_ldata", load_data, 64'h0123_4567_89AB_CDEF);
               check("mis_ext", 64'(ext_type), 64'd2);
               check("mis_done", 64'({done, reg_wr}), 64'b11);
`endif

        // Reset in the middle of WRITE
        cyc(); start = 1'b1; is_store = 1'b1; size = 2'b00; addr = 64'h5000;
               store_data = 64'h0F0F_0F0F_0F0F_0F0F;
        smp();
        cyc(); start = 1'b0;
        smp(); check("rw_wr", 64'(mem_wr), 64'd1);
        #2 reset = 1'b1;
        #1 check("rw_async", 64'({mem_wr, mem_rd, busy, done, err}), 64'd0);
        cyc(); reset = 1'b0;
        smp(); check("rw_after", 64'({busy, done, err}), 64'd0);

        // New ld after reset, with a start pulse while busy that must be dropped
        cyc(); start = 1'b1; is_store = 1'b0; size = 2'b00; addr = 64'h6000;
        smp();
        cyc(); start = 1'b1; is_store = 1'b1; size = 2'b00; addr = 64'h7000;
               store_data = 64'h1;
        smp(); check("busy_ign_addr", mem_addr, 64'h6000);
               check("busy_ign_bus", 64'({mem_rd, mem_wr}), 64'b10);
        cyc(); start = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h0000_0000_0000_CAFE;
        smp(); check("busy_ign_addr2", mem_addr, 64'h6000);
        cyc(); mem_ack = 1'b0;
        smp(); check("post_rst_done", 64'({done, reg_wr}), 64'b11);
               check("post_rst_ldata", load_data, 64'hCAFE);
               check("post_rst_ext", 64'(ext_type), 64'd0);
        cyc();
        smp(); check("no_queue1", 64'({busy, mem_wr, mem_rd}), 64'd0);
        cyc();
        smp(); check("no_queue2", 64'({busy, mem_wr, mem_rd}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
